// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Shares one single-port BRAM between the fetch (I) and load/store
//            (D) ports. D has priority, and a streak limit keeps fetch from
//            being starved. Optional macro MISALIGN_TRAP_EN makes misaligned
//            D accesses report an error instead of touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int LATENCY      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_valid_in,
    input  logic [31:0]       i_addr_in,
    output logic              i_ready_out,
    input  logic              i_flush_in,
    output logic              i_rsp_valid_out,
    output logic [31:0]       i_rsp_data_out,
    input  logic              d_valid_in,
    input  logic              d_we_in,
    input  logic [31:0]       d_addr_in,
    input  logic [31:0]       d_wdata_in,
    output logic              d_ready_out,
    output logic              d_rsp_valid_out,
    output logic [31:0]       d_rsp_data_out,
    output logic              d_err_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [31:0]       mem_din_out,
    output logic              mem_we_out,
    output logic              mem_en_out,
    input  logic [31:0]       mem_dout_in
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam int                    c_STREAK_W  = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);
    localparam logic [1:0]            c_WAIT_LOAD  = 2'(LATENCY - 2);

    logic [1:0]            r_state;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_squash;
    logic                  r_port_d;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_wait_cnt;

    logic w_idle;
    logic w_issue;
    logic w_done;
    logic w_grant_d;
    logic w_grant_i;
    logic w_err;

    // Address bits outside the word index never reach the BRAM.
    logic w_unused_addr;
    assign w_unused_addr = ^{i_addr_in[31:ADDR_W+2], i_addr_in[1:0],
                             d_addr_in[31:ADDR_W+2], d_addr_in[1:0]};

    assign w_idle  = rst_in && (r_state == c_ST_IDLE);
    assign w_issue = (r_state == c_ST_ISSUE);
    assign w_done  = (r_state == c_ST_DONE);

    // D wins ties unless it has used up its streak while I was waiting.
    assign w_grant_d = w_idle && d_valid_in && (!i_valid_in || (r_streak != c_STREAK_MAX));
    assign w_grant_i = w_idle && i_valid_in && !w_grant_d;

    assign d_ready_out = w_grant_d;
    assign i_ready_out = w_grant_i;

`ifdef MISALIGN_TRAP_EN
    logic r_err;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_err <= 1'b0;
        end else if (w_grant_d) begin
            r_err <= (d_addr_in[1:0] != 2'b00);
        end else if (w_grant_i) begin
            r_err <= 1'b0;
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    // Memory strobes decode straight from state so reset drops them at once.
    assign mem_en_out   = w_issue && !w_err;
    assign mem_we_out   = w_issue && r_we && !w_err;
    assign mem_addr_out = w_issue ? r_addr : '0;
    assign mem_din_out  = mem_we_out ? r_wdata : 32'd0;

    assign d_rsp_valid_out = w_done && r_port_d;
    assign d_rsp_data_out  = (w_done && r_port_d && !r_we && !w_err) ? mem_dout_in : 32'd0;
    assign d_err_out       = w_done && r_port_d && w_err;

    // A flush arriving in the DONE cycle itself still kills the response.
    assign i_rsp_valid_out = w_done && !r_port_d && !r_squash && !i_flush_in;
    assign i_rsp_data_out  = i_rsp_valid_out ? mem_dout_in : 32'd0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= c_ST_IDLE;
            r_streak   <= '0;
            r_squash   <= 1'b0;
            r_port_d   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_wait_cnt <= 2'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state  <= c_ST_ISSUE;
                        r_port_d <= 1'b1;
                        r_we     <= d_we_in;
                        r_addr   <= d_addr_in[ADDR_W+1:2];
                        r_wdata  <= d_we_in ? d_wdata_in : 32'd0;
                        r_squash <= 1'b0;
                        if (i_valid_in) begin
                            if (r_streak != c_STREAK_MAX) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end else if (w_grant_i) begin
                        r_state  <= c_ST_ISSUE;
                        r_port_d <= 1'b0;
                        r_we     <= 1'b0;
                        r_addr   <= i_addr_in[ADDR_W+1:2];
                        r_wdata  <= 32'd0;
                        r_squash <= i_flush_in;
                        r_streak <= '0;
                    end
                end
                c_ST_ISSUE: begin
                    if (!r_port_d && i_flush_in) begin
                        r_squash <= 1'b1;
                    end
                    if (LATENCY >= 2) begin
                        r_state    <= c_ST_WAIT;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_WAIT: begin
                    if (!r_port_d && i_flush_in) begin
                        r_squash <= 1'b1;
                    end
                    if (r_wait_cnt == 2'd0) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                c_ST_DONE: begin
                    r_state  <= c_ST_IDLE;
                    r_squash <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Brief    : Directed self-checking bench for unified_mem_arbiter (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic        clk_100mhz;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_flush;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;
    logic        d_valid;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_err;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_en;
    logic [31:0] mem_dout;

    int n_cmp;
    int n_err;

`ifdef MISALIGN_TRAP_EN
    localparam bit c_TRAP = 1'b1;
`else
    localparam bit c_TRAP = 1'b0;
`endif

    unified_mem_arbiter #(
        .ADDR_W       (12),
        .LATENCY      (2),
        .MAX_D_STREAK (4)
    ) dut (
        .clk_in          (clk_100mhz),
        .rst_in          (rst_n),
        .i_valid_in      (i_valid),
        .i_addr_in       (i_addr),
        .i_ready_out     (i_ready),
        .i_flush_in      (i_flush),
        .i_rsp_valid_out (i_rsp_valid),
        .i_rsp_data_out  (i_rsp_data),
        .d_valid_in      (d_valid),
        .d_we_in         (d_we),
        .d_addr_in       (d_addr),
        .d_wdata_in      (d_wdata),
        .d_ready_out     (d_ready),
        .d_rsp_valid_out (d_rsp_valid),
        .d_rsp_data_out  (d_rsp_data),
        .d_err_out       (d_err),
        .mem_addr_out    (mem_addr),
        .mem_din_out     (mem_din),
        .mem_we_out      (mem_we),
        .mem_en_out      (mem_en),
        .mem_dout_in     (mem_dout)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    // Two-cycle-latency BRAM model with a bench-side preload port.
    logic [31:0] mem [0:4095];
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk_100mhz) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        rd1 <= mem[mem_addr];
        end
        rd2 <= rd1;
    end
    assign mem_dout = rd2;

    logic [114:0] all_out;
    assign all_out = {i_ready, i_rsp_valid, i_rsp_data, d_ready, d_rsp_valid, d_rsp_data,
                      d_err, mem_addr, mem_din, mem_we, mem_en};

    task automatic tick;
        @(negedge clk_100mhz);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        tick();
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        i_valid = 1'b1; d_valid = 1'b1;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (all_out !== '0) begin
            n_err++; $display("FAIL reset_held: got %h want 0", all_out);
        end
        i_valid = 1'b0; d_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({i_ready, d_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_idle_ready: got %b want 00", {i_ready, d_ready});
        end
    endtask

    task automatic test_load;
        tick();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        #1;
        n_cmp++;
        if ({i_ready, d_ready} !== 2'b01) begin
            n_err++; $display("FAIL load_ready: got %b want 01", {i_ready, d_ready});
        end
        tick();
        n_cmp++;
        if ({d_ready, mem_en, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b0, 12'd5}) begin
            n_err++; $display("FAIL load_issue: got %b%b%b %h want 010 005",
                              d_ready, mem_en, mem_we, mem_addr);
        end
        d_valid = 1'b0;
        tick();
        n_cmp++;
        if ({mem_en, d_rsp_valid} !== 2'b00) begin
            n_err++; $display("FAIL load_wait: got %b want 00", {mem_en, d_rsp_valid});
        end
        tick();
        n_cmp++;
        if ({d_rsp_valid, d_rsp_data, i_rsp_valid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_err++; $display("FAIL load_rsp: got %b %h i=%b want 1 deadbeef i=0",
                              d_rsp_valid, d_rsp_data, i_rsp_valid);
        end
        tick();
        n_cmp++;
        if ({d_rsp_valid, d_rsp_data} !== 33'd0) begin
            n_err++; $display("FAIL load_rsp_clear: got %b %h want 0 0", d_rsp_valid, d_rsp_data);
        end
    endtask

    task automatic test_store_load;
        int we_cnt;
        we_cnt = 0;
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_err++; $display("FAIL store_ready: got %b want 1", d_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) d_valid = 1'b0;
            we_cnt += int'(mem_we);
            if (c == 1) begin
                n_cmp++;
                if ({mem_we, mem_addr, mem_din} !== {1'b1, 12'd8, 32'h1234_5678}) begin
                    n_err++; $display("FAIL store_issue: got %b %h %h want 1 008 12345678",
                                      mem_we, mem_addr, mem_din);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'd0}) begin
                    n_err++; $display("FAIL store_rsp: got %b %h want 1 0", d_rsp_valid, d_rsp_data);
                end
            end
        end
        n_cmp++;
        if (we_cnt !== 1) begin
            n_err++; $display("FAIL store_we_cycles: got %0d want 1", we_cnt);
        end
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        #1;
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_err++; $display("FAIL reload_ready: got %b want 1", d_ready);
        end
        tick();
        d_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'h1234_5678}) begin
            n_err++; $display("FAIL reload_rsp: got %b %h want 1 12345678", d_rsp_valid, d_rsp_data);
        end
        tick();
    endtask

    task automatic test_contention;
        logic [9:0] order;
        int         ng;
        logic       both;
        order = '0; ng = 0; both = 1'b0;
        i_valid = 1'b1; i_addr = 32'h0;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            #1;
            if (d_ready && i_ready) both = 1'b1;
            if (d_ready) begin
                order[9-ng] = 1'b1; ng++;
            end else if (i_ready) begin
                order[9-ng] = 1'b0; ng++;
            end
            tick();
        end
        i_valid = 1'b0; d_valid = 1'b0;
        n_cmp++;
        if (ng !== 10) begin
            n_err++; $display("FAIL contention_count: got %0d grants want 10", ng);
        end
        n_cmp++;
        if (order !== 10'b1111011110) begin
            n_err++; $display("FAIL contention_order: got %b want 1111011110 (1=D)", order);
        end
        n_cmp++;
        if (both !== 1'b0) begin
            n_err++; $display("FAIL contention_one_hot: got both=%b want 0", both);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_flush;
        int accept_cyc;
        accept_cyc = -1;
        i_valid = 1'b1; i_addr = 32'h8;
        #1;
        n_cmp++;
        if (i_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_ready: got %b want 1", i_ready);
        end
        for (int c = 1; c <= 8 && accept_cyc < 0; c++) begin
            tick();
            if (c == 2) i_flush = 1'b1;
            if (c == 3) i_flush = 1'b0;
            #1;
            if (c == 1) begin
                n_cmp++;
                if ({i_ready, mem_en, mem_addr} !== {1'b0, 1'b1, 12'd2}) begin
                    n_err++; $display("FAIL flush_issue: got %b%b %h want 01 002",
                                      i_ready, mem_en, mem_addr);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({i_rsp_valid, i_rsp_data} !== 33'd0) begin
                    n_err++; $display("FAIL flush_squash: got %b %h want 0 0", i_rsp_valid, i_rsp_data);
                end
            end
            if (i_ready) accept_cyc = c;
        end
        n_cmp++;
        if (accept_cyc !== 4) begin
            n_err++; $display("FAIL flush_next_accept: got cycle %0d want 4", accept_cyc);
        end
        tick();
        i_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({i_rsp_valid, i_rsp_data} !== {1'b1, 32'hA5A5_0002}) begin
            n_err++; $display("FAIL flush_refetch: got %b %h want 1 a5a50002", i_rsp_valid, i_rsp_data);
        end
        tick();
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h14; i_flush = 1'b1;
        tick();
        d_valid = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({d_rsp_valid, d_rsp_data} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL flush_d_unaffected: got %b %h want 1 deadbeef", d_rsp_valid, d_rsp_data);
        end
        i_flush = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int rsp_cnt;
        rsp_cnt = 0;
        d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        tick();
        d_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (all_out !== '0) begin
            n_err++; $display("FAIL reset_in_wait: got %h want 0", all_out);
        end
        tick();
        rst_n = 1'b1; i_valid = 1'b1; i_addr = 32'h8;
        #1;
        n_cmp++;
        if ({i_ready, d_ready} !== 2'b10) begin
            n_err++; $display("FAIL reset_release_ready: got %b want 10", {i_ready, d_ready});
        end
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rsp_cnt += int'(d_rsp_valid);
            tick();
        end
        n_cmp++;
        if (rsp_cnt !== 0) begin
            n_err++; $display("FAIL reset_abort_no_rsp: got %0d d responses want 0", rsp_cnt);
        end
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h0BAD_F00D;
        tick();
        d_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, mem_en} !== 2'b00) begin
            n_err++; $display("FAIL reset_async_we: got %b want 00", {mem_we, mem_en});
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_misalign;
        int we_cnt;
        we_cnt = 0;
        tick();
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h22; d_wdata = 32'hCAFE_0022;
        #1;
        n_cmp++;
        if (d_ready !== 1'b1) begin
            n_err++; $display("FAIL misalign_ready: got %b want 1", d_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) d_valid = 1'b0;
            we_cnt += int'(mem_we);
        end
        n_cmp++;
        if ({d_rsp_valid, d_err, d_rsp_data} !== {1'b1, c_TRAP, 32'd0}) begin
            n_err++; $display("FAIL misalign_rsp: got v=%b err=%b %h want v=1 err=%b 0",
                              d_rsp_valid, d_err, d_rsp_data, c_TRAP);
        end
        n_cmp++;
        if (we_cnt !== (c_TRAP ? 0 : 1)) begin
            n_err++; $display("FAIL misalign_we: got %0d want %0d", we_cnt, c_TRAP ? 0 : 1);
        end
        tick();
        n_cmp++;
        if (d_err !== 1'b0) begin
            n_err++; $display("FAIL misalign_err_clear: got %b want 0", d_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        i_valid = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
        d_valid = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        pre_we = 1'b0; pre_addr = 12'd0; pre_data = 32'd0;
        test_reset();
        preload(12'd5, 32'hDEADBEEF);
        preload(12'd2, 32'hA5A5_0002);
        test_load();
        test_store_load();
        test_contention();
        test_flush();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
